// File: rtl/softmax_pkg.sv
// Shared constants, candidate type and compare helper for the softmax max-scan datapath.
package softmax_pkg;

    localparam int N     = 64;
    localparam int W     = 16;
    localparam int WORDS = 16;
    localparam int IDX_W = $clog2(N * WORDS);

    typedef struct packed {
        logic signed [W-1:0] val;
        logic [IDX_W-1:0]    idx;
    } cand_t;

    // b wins only on a strict signed win, so the a side keeps ties.
    function automatic cand_t max2(input cand_t a, input cand_t b);
        return ($signed(b.val) > $signed(a.val)) ? b : a;
    endfunction

endpackage

// File: rtl/max_tree_stage.sv
// Combinational pairwise max reduction of IN candidates down to OUT candidates.
module max_tree_stage
    import softmax_pkg::*;
#(
    parameter int IN  = 64,
    parameter int OUT = 8
) (
    input  cand_t [IN-1:0]  i_cand,
    output cand_t [OUT-1:0] o_cand
);

    localparam int LEV = $clog2(IN / OUT);

    for (genvar l = 0; l <= LEV; l++) begin : g_lvl
        localparam int CNT = IN >> l;
        cand_t w_c [CNT];
        if (l == 0) begin : g_in
            for (genvar i = 0; i < CNT; i++) begin : g_leaf
                assign w_c[i] = i_cand[i];
            end
        end else begin : g_red
            // Lower-index candidate on the a side keeps lower-lane priority on ties.
            for (genvar i = 0; i < CNT; i++) begin : g_node
                assign w_c[i] = max2(g_lvl[l-1].w_c[2*i], g_lvl[l-1].w_c[2*i+1]);
            end
        end
    end

    for (genvar j = 0; j < OUT; j++) begin : g_out
        assign o_cand[j] = g_lvl[LEV].w_c[j];
    end

endmodule

// File: rtl/softmax_max_scan.sv
// Frame-wide signed max and lowest flat index of the max over WORDS words of N lanes.
module softmax_max_scan #(
    parameter int N     = softmax_pkg::N,
    parameter int W     = softmax_pkg::W,
    parameter int WORDS = softmax_pkg::WORDS,
    parameter int IDX_W = softmax_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   data_in,
    input  logic             valid_in,
    output logic [W-1:0]     max_out,
    output logic [IDX_W-1:0] max_idx,
    output logic             max_valid,
    output logic             frame_busy
);
    import softmax_pkg::*;

    localparam int WC_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int S2_OUT = 8;

    logic [WC_W-1:0]    r_wcnt, r_s1_wcnt;
    logic [N*W-1:0]     r_s1_data;
    logic [2:1]         r_vld_pipe, r_first_pipe, r_last_pipe;
    cand_t [N-1:0]      w_s1_cand;
    cand_t [S2_OUT-1:0] w_s2_cand, r_s2_cand;
    cand_t [0:0]        w_word;
    cand_t              w_merge, r_acc;
    logic [W-1:0]       r_max_out;
    logic [IDX_W-1:0]   r_max_idx;
    logic               r_max_valid, w_last_in, w_s3_done;

    assign w_last_in = (r_wcnt == WC_W'(WORDS - 1));

    // Word counter and valid/tag shift register; tags are qualified by valid at entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt       <= '0;
            r_vld_pipe   <= '0;
            r_first_pipe <= '0;
            r_last_pipe  <= '0;
        end else begin
            if (valid_in) r_wcnt <= w_last_in ? '0 : r_wcnt + WC_W'(1);
            r_vld_pipe   <= {r_vld_pipe[1], valid_in};
            r_first_pipe <= {r_first_pipe[1], valid_in && (r_wcnt == '0)};
            r_last_pipe  <= {r_last_pipe[1], valid_in && w_last_in};
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_s1_data <= data_in;
            r_s1_wcnt <= r_wcnt;
        end
        if (r_vld_pipe[1]) r_s2_cand <= w_s2_cand;
    end

    // Candidates carry the flat index so the trees need no later fix-up.
    for (genvar i = 0; i < N; i++) begin : g_cand
        assign w_s1_cand[i] = '{val: r_s1_data[i*W +: W],
                                idx: IDX_W'(r_s1_wcnt) * IDX_W'(N) + IDX_W'(i)};
    end

    max_tree_stage #(.IN(N), .OUT(S2_OUT)) u_tree_s2 (
        .i_cand (w_s1_cand),
        .o_cand (w_s2_cand)
    );

    max_tree_stage #(.IN(S2_OUT), .OUT(1)) u_tree_s3 (
        .i_cand (r_s2_cand),
        .o_cand (w_word)
    );

    // Accumulator on the a side so an earlier word keeps a tie.
    assign w_merge   = r_first_pipe[2] ? w_word[0] : max2(r_acc, w_word[0]);
    assign w_s3_done = r_vld_pipe[2] && r_last_pipe[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_max_out   <= '0;
            r_max_idx   <= '0;
            r_max_valid <= 1'b0;
        end else begin
            r_max_valid <= w_s3_done;
            if (r_vld_pipe[2]) r_acc <= w_merge;
            if (w_s3_done) begin
                r_max_out <= w_merge.val;
                r_max_idx <= w_merge.idx;
            end
        end
    end

    assign max_out    = r_max_out;
    assign max_idx    = r_max_idx;
    assign max_valid  = r_max_valid;
    assign frame_busy = (r_wcnt != '0) || r_last_pipe[1] || r_last_pipe[2] || r_max_valid;

endmodule

// File: tb/tb_softmax_max_scan.sv
// Scoreboard bench for softmax_max_scan: directed and random frames, gaps, back-to-back, reset.
module tb_softmax_max_scan;

    localparam int N     = 64;
    localparam int W     = 16;
    localparam int WORDS = 16;
    localparam int IDX_W = 10;

    typedef struct {
        logic [W-1:0] val;
        int           idx;
        int           cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_in = 1'b0;
    logic [N*W-1:0]   data_in = '0;
    logic [W-1:0]     max_out;
    logic [IDX_W-1:0] max_idx;
    logic             max_valid, frame_busy;

    logic [N*W-1:0] frm [WORDS];
    exp_t           sb [$];
    int             cyc = 0;
    int             n_tests = 0;
    int             n_fail = 0;
    int             acc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    softmax_max_scan #(.N(N), .W(W), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .max_out    (max_out),
        .max_idx    (max_idx),
        .max_valid  (max_valid),
        .frame_busy (frame_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void fill(input logic [W-1:0] v);
        for (int w = 0; w < WORDS; w++) frm[w] = {N{v}};
    endfunction

    function automatic void set_el(input int f, input logic [W-1:0] v);
        frm[f / N][(f % N)*W +: W] = v;
    endfunction

    // Linear scan in flat order; strict compare keeps the lowest index on ties.
    function automatic exp_t ref_max();
        exp_t         e;
        logic [W-1:0] v;
        e.val = frm[0][W-1:0];
        e.idx = 0;
        e.cyc = 0;
        for (int f = 1; f < N*WORDS; f++) begin
            v = frm[f / N][(f % N)*W +: W];
            if ($signed(v) > $signed(e.val)) begin
                e.val = v;
                e.idx = f;
            end
        end
        return e;
    endfunction

    task automatic drive_word(input int w);
        @(posedge clk); #1;
        valid_in = 1'b1;
        data_in  = frm[w];
    endtask

    // Idle cycles carry large garbage so a consumed bubble would show up.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            data_in  = {N{16'h7FFF}};
        end
    endtask

    task automatic send_frame(input logic [W-1:0] ev, input int ei, input bit use_ref, input bit gaps);
        exp_t e;
        if (use_ref) e = ref_max();
        else begin
            e.val = ev;
            e.idx = ei;
        end
        for (int w = 0; w < WORDS; w++) begin
            if (gaps && w != 0 && $urandom_range(0, 1) == 1) idle(1);
            drive_word(w);
        end
        e.cyc = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_max_out"}, max_out, 0);
        chk({tag, "_max_idx"}, max_idx, 0);
        chk({tag, "_max_valid"}, max_valid, 0);
        chk({tag, "_busy"}, frame_busy, 0);
    endtask

    // Monitor: busy model, scoreboard pop on each pulse, latency check.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acc_cnt <= 0;
            sb.delete();
        end else begin
            chk("frame_busy", frame_busy, (acc_cnt != 0 || sb.size() != 0));
            if (max_valid) begin
                if (sb.size() == 0) chk("unexpected_pulse", max_valid, 0);
                else begin
                    e = sb.pop_front();
                    chk("max_out", max_out, e.val);
                    chk("max_idx", max_idx, e.idx);
                    chk("latency_cycle", cyc, e.cyc);
                end
            end
            if (valid_in) acc_cnt <= (acc_cnt + 1) % WORDS;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst");

        // Single positive peak in a zero frame
        fill(16'h0000);
        set_el(5*N + 7, 16'h7FFF);
        send_frame(16'h7FFF, 327, 1'b0, 1'b0);
        drain();

        // All negative, peak -1 at the last element
        fill(16'h8000);
        set_el(1023, 16'hFFFF);
        send_frame(16'hFFFF, 1023, 1'b0, 1'b0);
        drain();

        // Ties within a word and across words
        fill(16'h0000);
        set_el(2*N + 40, 16'h0100);
        set_el(2*N + 3, 16'h0100);
        set_el(9*N + 0, 16'h0100);
        send_frame(16'h0100, 131, 1'b0, 1'b0);
        drain();

        // Back-to-back frames, no gap
        fill(16'h0010);
        set_el(0, 16'h1234);
        send_frame(16'h1234, 0, 1'b0, 1'b0);
        fill(16'h8000);
        set_el(500, 16'h0001);
        send_frame(16'h0001, 500, 1'b0, 1'b0);
        drain();

        // Random data with random single-cycle gaps
        repeat (2) begin
            for (int f = 0; f < N*WORDS; f++) set_el(f, 16'($urandom));
            send_frame('0, 0, 1'b1, 1'b1);
            drain();
        end

        // Partial frame of large values, then reset, then a fresh frame
        fill(16'h7FFF);
        for (int w = 0; w < 7; w++) drive_word(w);
        @(posedge clk); #1;
        valid_in = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        for (int f = 0; f < N*WORDS; f++) set_el(f, 16'($urandom_range(0, 16'h7000)));
        send_frame('0, 0, 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
